// File: rtl/inv_sub_bytes_serial.sv
// inv_sub_bytes_serial: AES InvSubBytes over a 128-bit state, four S-box lanes per BUSY cycle.
// Define INV_SUB_BYTES_FAST_EN for 16 lanes that substitute the whole state at capture.
module inv_sub_bytes_serial #(
  parameter int word_size  = 8,
  parameter int array_size = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [0:word_size*array_size-1]   Data_In,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [0:word_size*array_size-1]   Data_Out
);
  localparam int W = word_size * array_size;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [0:W-1] work_q, work_d;
  logic accept;
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s=8'h52; 8'h01: s=8'h09; 8'h02: s=8'h6a; 8'h03: s=8'hd5; 8'h04: s=8'h30; 8'h05: s=8'h36; 8'h06: s=8'ha5; 8'h07: s=8'h38;
      8'h08: s=8'hbf; 8'h09: s=8'h40; 8'h0a: s=8'ha3; 8'h0b: s=8'h9e; 8'h0c: s=8'h81; 8'h0d: s=8'hf3; 8'h0e: s=8'hd7; 8'h0f: s=8'hfb;
      8'h10: s=8'h7c; 8'h11: s=8'he3; 8'h12: s=8'h39; 8'h13: s=8'h82; 8'h14: s=8'h9b; 8'h15: s=8'h2f; 8'h16: s=8'hff; 8'h17: s=8'h87;
      8'h18: s=8'h34; 8'h19: s=8'h8e; 8'h1a: s=8'h43; 8'h1b: s=8'h44; 8'h1c: s=8'hc4; 8'h1d: s=8'hde; 8'h1e: s=8'he9; 8'h1f: s=8'hcb;
      8'h20: s=8'h54; 8'h21: s=8'h7b; 8'h22: s=8'h94; 8'h23: s=8'h32; 8'h24: s=8'ha6; 8'h25: s=8'hc2; 8'h26: s=8'h23; 8'h27: s=8'h3d;
      8'h28: s=8'hee; 8'h29: s=8'h4c; 8'h2a: s=8'h95; 8'h2b: s=8'h0b; 8'h2c: s=8'h42; 8'h2d: s=8'hfa; 8'h2e: s=8'hc3; 8'h2f: s=8'h4e;
      8'h30: s=8'h08; 8'h31: s=8'h2e; 8'h32: s=8'ha1; 8'h33: s=8'h66; 8'h34: s=8'h28; 8'h35: s=8'hd9; 8'h36: s=8'h24; 8'h37: s=8'hb2;
      8'h38: s=8'h76; 8'h39: s=8'h5b; 8'h3a: s=8'ha2; 8'h3b: s=8'h49; 8'h3c: s=8'h6d; 8'h3d: s=8'h8b; 8'h3e: s=8'hd1; 8'h3f: s=8'h25;
      8'h40: s=8'h72; 8'h41: s=8'hf8; 8'h42: s=8'hf6; 8'h43: s=8'h64; 8'h44: s=8'h86; 8'h45: s=8'h68; 8'h46: s=8'h98; 8'h47: s=8'h16;
      8'h48: s=8'hd4; 8'h49: s=8'ha4; 8'h4a: s=8'h5c; 8'h4b: s=8'hcc; 8'h4c: s=8'h5d; 8'h4d: s=8'h65; 8'h4e: s=8'hb6; 8'h4f: s=8'h92;
      8'h50: s=8'h6c; 8'h51: s=8'h70; 8'h52: s=8'h48; 8'h53: s=8'h50; 8'h54: s=8'hfd; 8'h55: s=8'hed; 8'h56: s=8'hb9; 8'h57: s=8'hda;
      8'h58: s=8'h5e; 8'h59: s=8'h15; 8'h5a: s=8'h46; 8'h5b: s=8'h57; 8'h5c: s=8'ha7; 8'h5d: s=8'h8d; 8'h5e: s=8'h9d; 8'h5f: s=8'h84;
      8'h60: s=8'h90; 8'h61: s=8'hd8; 8'h62: s=8'hab; 8'h63: s=8'h00; 8'h64: s=8'h8c; 8'h65: s=8'hbc; 8'h66: s=8'hd3; 8'h67: s=8'h0a;
      8'h68: s=8'hf7; 8'h69: s=8'he4; 8'h6a: s=8'h58; 8'h6b: s=8'h05; 8'h6c: s=8'hb8; 8'h6d: s=8'hb3; 8'h6e: s=8'h45; 8'h6f: s=8'h06;
      8'h70: s=8'hd0; 8'h71: s=8'h2c; 8'h72: s=8'h1e; 8'h73: s=8'h8f; 8'h74: s=8'hca; 8'h75: s=8'h3f; 8'h76: s=8'h0f; 8'h77: s=8'h02;
      8'h78: s=8'hc1; 8'h79: s=8'haf; 8'h7a: s=8'hbd; 8'h7b: s=8'h03; 8'h7c: s=8'h01; 8'h7d: s=8'h13; 8'h7e: s=8'h8a; 8'h7f: s=8'h6b;
      8'h80: s=8'h3a; 8'h81: s=8'h91; 8'h82: s=8'h11; 8'h83: s=8'h41; 8'h84: s=8'h4f; 8'h85: s=8'h67; 8'h86: s=8'hdc; 8'h87: s=8'hea;
      8'h88: s=8'h97; 8'h89: s=8'hf2; 8'h8a: s=8'hcf; 8'h8b: s=8'hce; 8'h8c: s=8'hf0; 8'h8d: s=8'hb4; 8'h8e: s=8'he6; 8'h8f: s=8'h73;
      8'h90: s=8'h96; 8'h91: s=8'hac; 8'h92: s=8'h74; 8'h93: s=8'h22; 8'h94: s=8'he7; 8'h95: s=8'had; 8'h96: s=8'h35; 8'h97: s=8'h85;
      8'h98: s=8'he2; 8'h99: s=8'hf9; 8'h9a: s=8'h37; 8'h9b: s=8'he8; 8'h9c: s=8'h1c; 8'h9d: s=8'h75; 8'h9e: s=8'hdf; 8'h9f: s=8'h6e;
      8'ha0: s=8'h47; 8'ha1: s=8'hf1; 8'ha2: s=8'h1a; 8'ha3: s=8'h71; 8'ha4: s=8'h1d; 8'ha5: s=8'h29; 8'ha6: s=8'hc5; 8'ha7: s=8'h89;
      8'ha8: s=8'h6f; 8'ha9: s=8'hb7; 8'haa: s=8'h62; 8'hab: s=8'h0e; 8'hac: s=8'haa; 8'had: s=8'h18; 8'hae: s=8'hbe; 8'haf: s=8'h1b;
      8'hb0: s=8'hfc; 8'hb1: s=8'h56; 8'hb2: s=8'h3e; 8'hb3: s=8'h4b; 8'hb4: s=8'hc6; 8'hb5: s=8'hd2; 8'hb6: s=8'h79; 8'hb7: s=8'h20;
      8'hb8: s=8'h9a; 8'hb9: s=8'hdb; 8'hba: s=8'hc0; 8'hbb: s=8'hfe; 8'hbc: s=8'h78; 8'hbd: s=8'hcd; 8'hbe: s=8'h5a; 8'hbf: s=8'hf4;
      8'hc0: s=8'h1f; 8'hc1: s=8'hdd; 8'hc2: s=8'ha8; 8'hc3: s=8'h33; 8'hc4: s=8'h88; 8'hc5: s=8'h07; 8'hc6: s=8'hc7; 8'hc7: s=8'h31;
      8'hc8: s=8'hb1; 8'hc9: s=8'h12; 8'hca: s=8'h10; 8'hcb: s=8'h59; 8'hcc: s=8'h27; 8'hcd: s=8'h80; 8'hce: s=8'hec; 8'hcf: s=8'h5f;
      8'hd0: s=8'h60; 8'hd1: s=8'h51; 8'hd2: s=8'h7f; 8'hd3: s=8'ha9; 8'hd4: s=8'h19; 8'hd5: s=8'hb5; 8'hd6: s=8'h4a; 8'hd7: s=8'h0d;
      8'hd8: s=8'h2d; 8'hd9: s=8'he5; 8'hda: s=8'h7a; 8'hdb: s=8'h9f; 8'hdc: s=8'h93; 8'hdd: s=8'hc9; 8'hde: s=8'h9c; 8'hdf: s=8'hef;
      8'he0: s=8'ha0; 8'he1: s=8'he0; 8'he2: s=8'h3b; 8'he3: s=8'h4d; 8'he4: s=8'hae; 8'he5: s=8'h2a; 8'he6: s=8'hf5; 8'he7: s=8'hb0;
      8'he8: s=8'hc8; 8'he9: s=8'heb; 8'hea: s=8'hbb; 8'heb: s=8'h3c; 8'hec: s=8'h83; 8'hed: s=8'h53; 8'hee: s=8'h99; 8'hef: s=8'h61;
      8'hf0: s=8'h17; 8'hf1: s=8'h2b; 8'hf2: s=8'h04; 8'hf3: s=8'h7e; 8'hf4: s=8'hba; 8'hf5: s=8'h77; 8'hf6: s=8'hd6; 8'hf7: s=8'h26;
      8'hf8: s=8'he1; 8'hf9: s=8'h69; 8'hfa: s=8'h14; 8'hfb: s=8'h63; 8'hfc: s=8'h55; 8'hfd: s=8'h21; 8'hfe: s=8'h0c; 8'hff: s=8'h7d;
      default: s=8'h00;
    endcase
    return s;
  endfunction
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    work_d = work_q;
    out_valid = state_q == DONE;
    in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    accept = in_valid && in_ready;
    case (state_q)
      BUSY: begin
        for (int i = 0; i < 4; i++)
          work_d[4*word_size*col_q + word_size*i +: word_size] = inv_sbox(work_q[4*word_size*col_q + word_size*i +: word_size]);
        col_d = col_q + 2'd1;
        state_d = col_q == 2'd3 ? DONE : BUSY;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: ;
    endcase
    // a capture in DONE overrides the return to IDLE so back-to-back states lose no cycle
    if (accept) begin
`ifdef INV_SUB_BYTES_FAST_EN
      for (int i = 0; i < array_size; i++)
        work_d[word_size*i +: word_size] = inv_sbox(Data_In[word_size*i +: word_size]);
      state_d = DONE;
`else
      work_d = Data_In;
      state_d = BUSY;
`endif
      col_d = 2'd0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      col_q <= 2'd0;
      work_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      work_q <= work_d;
    end
  end
  assign Data_Out = work_q;
endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
// tb_inv_sub_bytes_serial: directed and randomized checks against an inverse S-box
// derived from GF(2^8) inversion and the forward affine map.
module tb_inv_sub_bytes_serial;
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [0:127] Data_In = '0, Data_Out;
  logic [7:0] isb [256];
  int n_chk = 0, n_pass = 0;
`ifdef INV_SUB_BYTES_FAST_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 4;
`endif
  always #5 clk = ~clk;
  inv_sub_bytes_serial dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Data_In(Data_In), .out_valid(out_valid), .out_ready(out_ready), .Data_Out(Data_Out)
  );
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction
  function automatic logic [0:127] fill(input logic [7:0] b);
    logic [0:127] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = b;
    return v;
  endfunction
  function automatic logic [0:127] ref_inv(input logic [0:127] s);
    logic [0:127] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = isb[s[8*k +: 8]];
    return v;
  endfunction
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("valid_seen", out_valid, 1);
  endtask
  initial begin
    int lat;
    int sent, recv, cyc;
    bit fire;
    logic [0:127] d, e, a;
    logic [0:127] q[$];
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      isb[s] = 8'(x);
    end
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data_out", Data_Out, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // single 0x63 state, one-cycle in_valid
    Data_In = fill(8'h63); in_valid = 1'b1; out_ready = 1'b1;
    #1 check("idle_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid(lat);
    check("lat_63", lat, LAT);
    check("data_63", Data_Out, fill(8'h00));
    @(posedge clk); #1 check("pulse_63", out_valid, 0);
    // back-to-back 0x00 then 0x52 with in_valid held
    Data_In = fill(8'h00); in_valid = 1'b1;
    @(posedge clk); #1 Data_In = fill(8'h52);
    wait_valid(lat);
    check("data_00", Data_Out, fill(8'h52));
    check("done_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid(lat);
    check("lat_52", lat, LAT);
    check("data_52", Data_Out, fill(8'h48));
    @(posedge clk); #1 check("pulse_52", out_valid, 0);
    // output stall for ten cycles
    out_ready = 1'b0;
    d = fill(8'h63); d[0 +: 8] = 8'h16; d[120 +: 8] = 8'h7c;
    e = fill(8'h00); e[0 +: 8] = 8'hff; e[120 +: 8] = 8'h01;
    Data_In = d; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_data", Data_Out, e);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 check("stall_release", out_valid, 0);
    // reset in the second BUSY cycle discards the state
    Data_In = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_data_out", Data_Out, 0);
    check("midrst_in_ready", in_ready, 1);
    out_ready = 1'b0;
    @(negedge clk);
    a = {$urandom, $urandom, $urandom, $urandom};
    Data_In = a; in_valid = 1'b1; reset_n = 1'b1;
    // first edge after release captures; later in_valid toggles are ignored
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2) == 0;
      Data_In = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_valid(lat);
    check("ignore_data", Data_Out, ref_inv(a));
    @(posedge clk); #1 check("ignore_pulse", out_valid, 0);
    // randomized traffic with random stalls
    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 30000) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        Data_In = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (out_valid && out_ready) begin
        check("rand_expected", q.size() != 0, 1);
        if (q.size() != 0) check("rand_data", Data_Out, q.pop_front());
        recv++;
      end
      fire = in_valid && in_ready;
      if (fire) begin
        q.push_back(ref_inv(Data_In));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (fire) in_valid = 1'b0;
    end
    check("rand_recv", recv, 1000);
    check("rand_left", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
